ws_pixel_tx: RTL and testbench

- Serial one-wire LED transmitter: drive side of the pulse-width LED data line that the receive path measures with its tick-enable counter.
- Accepts DATA_WIDTH-bit pixel words over a valid/ready handshake and shifts them out MSB first as high-time-coded bits.
  - Short high = 0, long high = 1, fixed bit period.
- Appends a low latch interval when the stream runs dry.
- Sits between the pixel source (frame/pattern logic) and the LED output pin.

---
 rtl/ws_pixel_tx.sv | 134 +++++++++++++
 tb/tb_ws_pixel_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_pixel_tx.sv
// One-wire LED transmitter: shifts pixel words out MSB first as high-time-coded bits,
// then holds the line low for a latch interval once the pixel stream runs dry.
module ws_pixel_tx #(
   parameter int DATA_WIDTH  = 24,
   parameter int TICK_DIV    = 5,
   parameter int T0H_TICKS   = 4,
   parameter int T1H_TICKS   = 8,
   parameter int BIT_TICKS   = 12,
   parameter int LATCH_TICKS = 600
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic                  o_dout,
   output logic                  o_busy,
   output logic                  o_frame_done
);

   localparam int PHASE_MAX = (BIT_TICKS > LATCH_TICKS) ? BIT_TICKS : LATCH_TICKS;
   localparam int CW        = $clog2(PHASE_MAX + 1);
   localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HIGH  = 2'd1;
   localparam logic [1:0] ST_LOW   = 2'd2;
   localparam logic [1:0] ST_LATCH = 2'd3;

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BW-1:0]         bit_idx;
   logic [PW-1:0]         presc;
   logic [CW-1:0]         tick_cnt;
   logic [CW-1:0]         phase_last;
   logic                  tick_end;
   logic                  phase_end;
   logic                  transfer;

   // Last tick index of the current phase; high/low split depends on the bit being sent.
   always_comb begin
      phase_last = '0;
      case (state)
         ST_HIGH:  phase_last = shift_reg[DATA_WIDTH-1] ? CW'(T1H_TICKS - 1)
                                                        : CW'(T0H_TICKS - 1);
         ST_LOW:   phase_last = shift_reg[DATA_WIDTH-1] ? CW'(BIT_TICKS - T1H_TICKS - 1)
                                                        : CW'(BIT_TICKS - T0H_TICKS - 1);
         ST_LATCH: phase_last = CW'(LATCH_TICKS - 1);
         default:  phase_last = '0;
      endcase
   end

   assign tick_end  = (presc == PW'(TICK_DIV - 1));
   assign phase_end = tick_end && (tick_cnt == phase_last);
   assign o_ready   = (state == ST_IDLE) ||
                      ((state == ST_LOW) && (bit_idx == '0) && phase_end);
   assign transfer  = i_valid && o_ready;
   assign o_busy    = (state != ST_IDLE);

   // Prescaler and tick counter restart at every phase boundary so phases never jitter.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         presc    <= '0;
         tick_cnt <= '0;
      end else if ((state == ST_IDLE) || phase_end) begin
         presc    <= '0;
         tick_cnt <= '0;
      end else if (tick_end) begin
         presc    <= '0;
         tick_cnt <= tick_cnt + 1'b1;
      end else begin
         presc    <= presc + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= ST_IDLE;
         shift_reg    <= '0;
         bit_idx      <= '0;
         o_dout       <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_dout <= 1'b0;
               if (transfer) begin
                  shift_reg <= i_data;
                  bit_idx   <= BW'(DATA_WIDTH - 1);
                  o_dout    <= 1'b1;
                  state     <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (phase_end) begin
                  o_dout <= 1'b0;
                  state  <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (phase_end) begin
                  if (bit_idx != '0) begin
                     shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                     bit_idx   <= bit_idx - 1'b1;
                     o_dout    <= 1'b1;
                     state     <= ST_HIGH;
                  end else if (transfer) begin
                     shift_reg <= i_data;
                     bit_idx   <= BW'(DATA_WIDTH - 1);
                     o_dout    <= 1'b1;
                     state     <= ST_HIGH;
                  end else begin
                     state     <= ST_LATCH;
                  end
               end
            end
            ST_LATCH: begin
               o_dout <= 1'b0;
               if (phase_end) begin
                  o_frame_done <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            default: begin
               o_dout <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws_pixel_tx.sv
// Scoreboard bench for ws_pixel_tx: a monitor decodes the LED line by pulse widths and
// checks each recovered pixel, bit period, latch length and handshake against expectations.
module tb_ws_pixel_tx;

   localparam int DW        = 24;
   localparam int TD        = 2;
   localparam int T0        = 2;
   localparam int T1        = 4;
   localparam int BT        = 6;
   localparam int LT        = 10;
   localparam int BIT_CYC   = BT * TD;
   localparam int LATCH_CYC = LT * TD;
   localparam int T0_CYC    = T0 * TD;
   localparam int T1_CYC    = T1 * TD;
   localparam int PIX_CYC   = DW * BIT_CYC;

   logic          i_clk = 1'b0;
   logic          i_reset_n = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic          o_dout;
   logic          o_busy;
   logic          o_frame_done;

   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] sb[$];

   int            mcycle = 0;
   int            nbits = 0;
   int            high_len = 0;
   int            last_rise = 0;
   bit            pending = 1'b0;
   bit            prev_dout = 1'b0;
   logic [DW-1:0] rx_word = '0;
   bit            mon_rise, mon_fall, exp_fd, exp_busy, exp_ready, exp_bit;
   bit            last_fd = 1'b0;

   ws_pixel_tx #(
      .DATA_WIDTH(DW), .TICK_DIV(TD), .T0H_TICKS(T0), .T1H_TICKS(T1),
      .BIT_TICKS(BT), .LATCH_TICKS(LT)
   ) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_data(i_data), .i_valid(i_valid),
      .o_ready(o_ready), .o_dout(o_dout), .o_busy(o_busy), .o_frame_done(o_frame_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: decodes pulse widths into pixels and tracks when latch/ready/busy are due.
   always @(negedge i_clk) begin
      mcycle++;
      if (!i_reset_n) begin
         check_output("reset_dout", o_dout, 0);
         check_output("reset_busy", o_busy, 0);
         check_output("reset_frame_done", o_frame_done, 0);
         nbits = 0; pending = 0; prev_dout = 0; high_len = 0; rx_word = '0;
      end else begin
         mon_rise = o_dout && !prev_dout;
         mon_fall = !o_dout && prev_dout;
         if (mon_rise) begin
            if (nbits > 0 || pending)
               check_output("bit_period", mcycle - last_rise, BIT_CYC);
            pending   = 0;
            last_rise = mcycle;
            high_len  = 0;
         end
         if (o_dout) high_len++;
         if (mon_fall) begin
            check_output("pulse_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               exp_bit = sb[0][DW-1-nbits];
               check_output("high_time", high_len, exp_bit ? T1_CYC : T0_CYC);
               rx_word = {rx_word[DW-2:0], high_len == T1_CYC};
               nbits++;
               if (nbits == DW) begin
                  check_output("pixel_word", rx_word, sb.pop_front());
                  nbits   = 0;
                  pending = 1;
               end
            end
         end
         exp_fd    = pending && (mcycle == last_rise + BIT_CYC + LATCH_CYC);
         exp_busy  = o_dout || (nbits > 0) || (pending && !exp_fd);
         exp_ready = !exp_busy || (pending && (mcycle == last_rise + BIT_CYC - 1));
         check_output("frame_done", o_frame_done, exp_fd);
         check_output("busy", o_busy, exp_busy);
         check_output("ready", o_ready, exp_ready);
         if (exp_fd) pending = 0;
         prev_dout = o_dout;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Offers one pixel and waits (bounded) for the handshake; pushes the expectation on transfer.
   task automatic apply_stimulus(input logic [DW-1:0] d, input bit keep, input bit wiggle,
                                 input int exp_wait);
      int n = 0;
      bit ok = 0;
      i_valid = 1'b1;
      i_data  = d;
      for (int k = 0; k < 2000; k++) begin
         @(negedge i_clk);
         if (o_ready === 1'b1) begin
            i_valid = 1'b1;
            ok = 1;
            break;
         end
         n++;
         if (wiggle) i_valid = 1'($urandom_range(0, 1));
      end
      check_output("ready_seen", ok, 1);
      if (ok) begin
         last_fd = o_frame_done;
         if (exp_wait >= 0) check_output("ready_wait", n, exp_wait);
         @(posedge i_clk);
         sb.push_back(d);
         #1;
         check_output("dout_latency", o_dout, 1);
         check_output("busy_on_transfer", o_busy, 1);
      end
      if (!keep) i_valid = 1'b0;
      i_data = DW'($urandom);
   endtask

   task automatic wait_done();
      bit done = 0;
      for (int k = 0; k < 5000; k++) begin
         @(posedge i_clk);
         if (sb.size() == 0 && !pending && nbits == 0) begin
            done = 1;
            break;
         end
      end
      check_output("drain", done, 1);
      #1;
   endtask

   task automatic pulse_reset();
      #1;
      i_reset_n = 1'b0;
      sb.delete();
      #1;
      check_output("async_reset_dout", o_dout, 0);
      check_output("async_reset_busy", o_busy, 0);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      #2;
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;
      check_output("post_reset_ready", o_ready, 1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DW-1:0] d;
      int mode;
      $display("[TB] ws_pixel_tx scoreboard bench starting");
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      #2;
      i_reset_n = 1'b1;
      idle(2);
      check_output("init_ready", o_ready, 1);

      // Reset asserted in the middle of a bit.
      apply_stimulus(24'hC3A5F0, 0, 0, 0);
      idle(5);
      pulse_reset();
      idle(10);

      // Single pixel followed by latch.
      apply_stimulus(24'hA50000, 0, 0, 0);
      wait_done();
      idle(3);

      // Back-to-back pixels with valid held; ready appears only in the last cycle.
      apply_stimulus(24'hFFFFFF, 1, 0, 0);
      apply_stimulus(24'h000000, 0, 0, PIX_CYC - 1);
      wait_done();
      idle(3);

      // Valid offered 5 cycles into latch: held off until IDLE.
      apply_stimulus(24'h5A5A5A, 0, 0, 0);
      idle(PIX_CYC + 5);
      apply_stimulus(24'h123456, 0, 0, LATCH_CYC - 5);
      check_output("xfer_on_frame_done", last_fd, 1);
      wait_done();

      // Backpressure: long idle with valid low.
      idle(50);
      check_output("idle_busy", o_busy, 0);
      check_output("idle_ready", o_ready, 1);
      apply_stimulus(24'h00FF00, 0, 0, 0);
      wait_done();

      // Reset during latch: no frame_done, then a full-timing pixel.
      apply_stimulus(24'h0F0F0F, 0, 0, 0);
      idle(PIX_CYC + 8);
      pulse_reset();
      idle(30);
      apply_stimulus(DW'($urandom), 0, 0, 0);
      wait_done();

      // Randomised traffic mix.
      for (int i = 0; i < 10; i++) begin
         d    = DW'($urandom);
         mode = (i == 9) ? 2 : $urandom_range(0, 2);
         case (mode)
            0: apply_stimulus(d, 1, 0, -1);
            1: apply_stimulus(d, 0, 1, -1);
            default: begin
               apply_stimulus(d, 0, 0, -1);
               idle($urandom_range(0, 40));
            end
         endcase
      end
      wait_done();
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
